// File: rtl/snake_body_engine_if.sv
// Bundles the snake engine's control inputs, renderer query and status outputs.
// The master drives the controls and query; the engine is the slave.
interface snake_body_engine_if #(
  parameter int X_W   = 5,
  parameter int Y_W   = 5,
  parameter int LEN_W = 5
);
  logic [1:0]       move_direction;
  logic             step_tick;
  logic             grow;
  logic [X_W-1:0]   query_x;
  logic [Y_W-1:0]   query_y;
  logic             query_hit;
  logic             query_head;
  logic [X_W-1:0]   head_x;
  logic [Y_W-1:0]   head_y;
  logic [LEN_W-1:0] length;
  logic [1:0]       cur_dir;
  logic             game_over;

  modport master (
    output move_direction, step_tick, grow, query_x, query_y,
    input  query_hit, query_head, head_x, head_y, length, cur_dir, game_over
  );

  modport slave (
    input  move_direction, step_tick, grow, query_x, query_y,
    output query_hit, query_head, head_x, head_y, length, cur_dir, game_over
  );
endinterface

// File: rtl/snake_body_engine.sv
// Snake body as a segment shift buffer: steering filter, growth, wall/self
// collision detection and a combinational per-cell occupancy query.
module snake_body_engine #(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int X_W      = 5,
  parameter int Y_W      = 5,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3,
  parameter int LEN_W    = $clog2(MAX_LEN + 1)
) (
  input logic                clk,
  input logic                reset,
  snake_body_engine_if.slave bus
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_DEAD = 1'b1
  } state_t;

  localparam logic [1:0] DIR_LEFT  = 2'd0;
  localparam logic [1:0] DIR_UP    = 2'd1;
  localparam logic [1:0] DIR_RIGHT = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  state_t           state_q, state_d;
  logic [X_W-1:0]   seg_x_q [MAX_LEN];
  logic [X_W-1:0]   seg_x_d [MAX_LEN];
  logic [Y_W-1:0]   seg_y_q [MAX_LEN];
  logic [Y_W-1:0]   seg_y_d [MAX_LEN];
  logic [LEN_W-1:0] length_q, length_d;
  logic [1:0]       cur_dir_q, cur_dir_d;
  logic             grow_pend_q, grow_pend_d;

  logic [1:0]       filt_dir_s;
  logic             wall_s;
  logic             self_hit_s;
  logic             grow_eff_s;
  logic [LEN_W-1:0] self_lim_s;
  logic [X_W-1:0]   next_x_s;
  logic [Y_W-1:0]   next_y_s;
  logic             query_hit_s;

  function automatic logic [X_W-1:0] init_x(input int idx);
    if (idx < INIT_LEN) begin
      return X_W'(GRID_W / 2 - idx);
    end else begin
      return {X_W{1'b0}};
    end
  endfunction

  // Steering filter, next head cell and collision detection for a step.
  always_comb begin
    filt_dir_s = bus.move_direction;
    wall_s     = 1'b0;
    self_hit_s = 1'b0;
    next_x_s   = seg_x_q[0];
    next_y_s   = seg_y_q[0];
    if (bus.move_direction == (cur_dir_q ^ 2'd2)) begin
      filt_dir_s = cur_dir_q;
    end else begin
      filt_dir_s = bus.move_direction;
    end
    // Wall test uses the current coordinate so no wrapped value is ever judged.
    case (filt_dir_s)
      DIR_LEFT: begin
        wall_s   = (seg_x_q[0] == {X_W{1'b0}});
        next_x_s = seg_x_q[0] - X_W'(1);
      end
      DIR_UP: begin
        wall_s   = (seg_y_q[0] == {Y_W{1'b0}});
        next_y_s = seg_y_q[0] - Y_W'(1);
      end
      DIR_RIGHT: begin
        wall_s   = (seg_x_q[0] == X_W'(GRID_W - 1));
        next_x_s = seg_x_q[0] + X_W'(1);
      end
      DIR_DOWN: begin
        wall_s   = (seg_y_q[0] == Y_W'(GRID_H - 1));
        next_y_s = seg_y_q[0] + Y_W'(1);
      end
      default: begin
        wall_s = 1'b1;
      end
    endcase
    // A saturated growth does not keep the tail, so it moves like a plain step.
    grow_eff_s = (grow_pend_q | bus.grow) & (length_q < LEN_W'(MAX_LEN));
    if (grow_eff_s) begin
      self_lim_s = length_q - LEN_W'(1);
    end else begin
      self_lim_s = length_q - LEN_W'(2);
    end
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((LEN_W'(i) <= self_lim_s) && (seg_x_q[i] == next_x_s) &&
          (seg_y_q[i] == next_y_s)) begin
        self_hit_s = 1'b1;
      end else begin
        self_hit_s = self_hit_s;
      end
    end
  end

  // Run/dead state machine and body, length, direction and growth updates.
  always_comb begin
    state_d     = state_q;
    seg_x_d     = seg_x_q;
    seg_y_d     = seg_y_q;
    length_d    = length_q;
    cur_dir_d   = cur_dir_q;
    grow_pend_d = grow_pend_q;
    case (state_q)
      ST_RUN: begin
        if (bus.step_tick) begin
          if (wall_s | self_hit_s) begin
            state_d = ST_DEAD;
          end else begin
            for (int i = 1; i < MAX_LEN; i++) begin
              seg_x_d[i] = seg_x_q[i-1];
              seg_y_d[i] = seg_y_q[i-1];
            end
            seg_x_d[0]  = next_x_s;
            seg_y_d[0]  = next_y_s;
            cur_dir_d   = filt_dir_s;
            grow_pend_d = 1'b0;
            if (grow_eff_s) begin
              length_d = length_q + LEN_W'(1);
            end else begin
              length_d = length_q;
            end
          end
        end else if (bus.grow) begin
          grow_pend_d = 1'b1;
        end else begin
          grow_pend_d = grow_pend_q;
        end
      end
      ST_DEAD: begin
        state_d = ST_DEAD;
      end
      default: begin
        state_d = ST_DEAD;
      end
    endcase
  end

  // State registers with the centred horizontal starting body on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      length_q    <= LEN_W'(INIT_LEN);
      cur_dir_q   <= DIR_RIGHT;
      grow_pend_q <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= init_x(i);
        seg_y_q[i] <= (i < INIT_LEN) ? Y_W'(GRID_H / 2) : {Y_W{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      length_q    <= length_d;
      cur_dir_q   <= cur_dir_d;
      grow_pend_q <= grow_pend_d;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= seg_x_d[i];
        seg_y_q[i] <= seg_y_d[i];
      end
    end
  end

  // Occupancy query; entries at or beyond the live length are stale.
  always_comb begin
    query_hit_s = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LEN_W'(i) < length_q) && (seg_x_q[i] == bus.query_x) &&
          (seg_y_q[i] == bus.query_y)) begin
        query_hit_s = 1'b1;
      end else begin
        query_hit_s = query_hit_s;
      end
    end
  end

  assign bus.query_hit  = query_hit_s;
  assign bus.query_head = (seg_x_q[0] == bus.query_x) && (seg_y_q[0] == bus.query_y);
  assign bus.head_x     = seg_x_q[0];
  assign bus.head_y     = seg_y_q[0];
  assign bus.length     = length_q;
  assign bus.cur_dir    = cur_dir_q;
  assign bus.game_over  = (state_q == ST_DEAD);

endmodule

// File: tb/tb_snake_body_engine.sv
// Directed bench for snake_body_engine on a 32x24 grid, MAX_LEN 16, INIT_LEN 3,
// with hand-computed expected coordinates, lengths and directions.
module tb_snake_body_engine;

  logic clk;
  logic reset;
  int   checks_cnt;
  int   errors_cnt;

  snake_body_engine_if #(.X_W(5), .Y_W(5), .LEN_W(5)) bus ();

  snake_body_engine #(
    .GRID_W(32), .GRID_H(24), .X_W(5), .Y_W(5), .MAX_LEN(16), .INIT_LEN(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_step(input logic [1:0] dir, input logic g);
    @(negedge clk);
    bus.move_direction = dir;
    bus.step_tick      = 1'b1;
    bus.grow           = g;
    @(negedge clk);
    bus.step_tick = 1'b0;
    bus.grow      = 1'b0;
  endtask

  task automatic pulse_grow();
    @(negedge clk);
    bus.grow = 1'b1;
    @(negedge clk);
    bus.grow = 1'b0;
  endtask

  task automatic probe(input string tag, input int x, input int y,
                       input logic exp_hit, input logic exp_head);
    bus.query_x = 5'(x);
    bus.query_y = 5'(y);
    #1;
    check_eq({tag, "_hit"}, {31'd0, bus.query_hit}, {31'd0, exp_hit});
    check_eq({tag, "_head"}, {31'd0, bus.query_head}, {31'd0, exp_head});
  endtask

  task automatic check_state(input string tag, input int x, input int y,
                             input int len, input int dir, input logic over);
    check_eq({tag, "_hx"}, 32'(bus.head_x), 32'(x));
    check_eq({tag, "_hy"}, 32'(bus.head_y), 32'(y));
    check_eq({tag, "_len"}, 32'(bus.length), 32'(len));
    check_eq({tag, "_dir"}, 32'(bus.cur_dir), 32'(dir));
    check_eq({tag, "_over"}, {31'd0, bus.game_over}, {31'd0, over});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    checks_cnt         = 0;
    errors_cnt         = 0;
    reset              = 1'b0;
    bus.move_direction = 2'd2;
    bus.step_tick      = 1'b0;
    bus.grow           = 1'b0;
    bus.query_x        = 5'd0;
    bus.query_y        = 5'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Reset body (16,12),(15,12),(14,12)
    check_state("rst", 16, 12, 3, 2, 1'b0);
    probe("rst_tail", 14, 12, 1'b1, 1'b0);
    probe("rst_beyond", 13, 12, 1'b0, 1'b0);
    probe("rst_head", 16, 12, 1'b1, 1'b1);

    // Turn down: body (16,13),(16,12),(15,12); stale seg3 holds (14,12)
    do_step(2'd3, 1'b0);
    check_state("down", 16, 13, 3, 3, 1'b0);
    probe("down_s1", 16, 12, 1'b1, 1'b0);
    probe("down_s2", 15, 12, 1'b1, 1'b0);
    probe("down_stale", 14, 12, 1'b0, 1'b0);

    // Right, then a reverse request that must be ignored
    do_step(2'd2, 1'b0);
    check_state("right", 17, 13, 3, 2, 1'b0);
    do_step(2'd0, 1'b0);
    check_state("rev", 18, 13, 3, 2, 1'b0);

    // Two merged grows: body (19,13),(18,13),(17,13),(16,13)
    pulse_grow();
    pulse_grow();
    do_step(2'd2, 1'b0);
    check_state("grow2", 19, 13, 4, 2, 1'b0);
    probe("grow2_tail", 16, 13, 1'b1, 1'b0);
    probe("grow2_beyond", 15, 13, 1'b0, 1'b0);

    // Tail chase around a 2x2 square at length 4
    do_step(2'd3, 1'b0);
    do_step(2'd0, 1'b0);
    do_step(2'd1, 1'b0);
    do_step(2'd2, 1'b0);
    check_state("chase", 19, 13, 4, 2, 1'b0);
    probe("chase_tail", 19, 14, 1'b1, 1'b0);

    // Into the tail while growing: collision, everything frozen
    pulse_grow();
    do_step(2'd3, 1'b0);
    check_state("tailgrow", 19, 13, 4, 2, 1'b1);
    do_step(2'd1, 1'b1);
    check_state("dead_ign", 19, 13, 4, 2, 1'b1);

    // Asynchronous reset away from a clock edge, step ignored while low
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_state("async_rst", 16, 12, 3, 2, 1'b0);
    bus.move_direction = 2'd3;
    bus.step_tick      = 1'b1;
    @(negedge clk);
    bus.step_tick = 1'b0;
    check_state("rst_step", 16, 12, 3, 2, 1'b0);
    reset = 1'b1;

    // Right wall at x=31
    for (int i = 0; i < 15; i++) do_step(2'd2, 1'b0);
    check_state("at_wall", 31, 12, 3, 2, 1'b0);
    do_step(2'd2, 1'b0);
    check_state("wall", 31, 12, 3, 2, 1'b1);
    do_step(2'd3, 1'b1);
    check_state("wall_ign", 31, 12, 3, 2, 1'b1);

    // Grow to MAX_LEN, then saturation
    do_reset();
    for (int i = 0; i < 13; i++) do_step(2'd2, 1'b1);
    check_state("full", 29, 12, 16, 2, 1'b0);
    do_step(2'd2, 1'b1);
    check_state("sat", 30, 12, 16, 2, 1'b0);
    do_step(2'd2, 1'b0);
    check_state("sat2", 31, 12, 16, 2, 1'b0);
    probe("sat_tail", 16, 12, 1'b1, 1'b0);
    probe("sat_beyond", 15, 12, 1'b0, 1'b0);

    // Grow then down/left/up lands on own body
    do_reset();
    do_step(2'd3, 1'b1);
    do_step(2'd0, 1'b1);
    check_state("self_pre", 15, 13, 5, 0, 1'b0);
    do_step(2'd1, 1'b0);
    check_state("self", 15, 13, 5, 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
